cdc_hs_arbiter: RTL and testbench
=================================

# cdc_hs_arbiter

Source-domain arbiter and four-phase handshake sequencer that shares one 1-bit level-synchronized crossing channel among N_REQ requesters. It drives the channel's request level into the bit synchronizer, holds the selected requester's payload stable, and waits for the acknowledge level returned through a synchronizer from the far domain. It reports completion or timeout to the granted requester. It sits in the a_clk domain, in front of the request-bit synchronizer.

## Interface
- N_REQ, 4, number of requesters (2..16)
- DATA_W, 8, payload width per requester
- TMO_CYC, 255, max cycles in REQ_HI waiting for ack high; 0 disables the timeout
- a_clk  in  1  source-domain clock
- a_rst_n  in  1  asynchronous reset, active-high despite the suffix; clears all state immediately
- req  in  N_REQ  level per requester; held high until the matching done pulse is sampled
- req_data  in  N_REQ*DATA_W  payload, slice i belongs to requester i
- done  out  N_REQ  one-cycle completion pulse to the granted requester
- err  out  N_REQ  one-cycle pulse, coincident with done, when the transfer timed out
- xfer_req  out  1  handshake request level to the synchronizer async input
- xfer_data  out  DATA_W  latched payload, stable from the xfer_req rise until done
- xfer_ack_sync  in  1  acknowledge level, already synchronized into a_clk
- busy  out  1  high in any state other than IDLE
- grant_id  out  $clog2(N_REQ)  index of the current or last granted requester

## Operation
- States: IDLE, REQ_HI, ACK_LO, DONE.
- IDLE:
  - Arbitration runs only when xfer_ack_sync==0.
  - If any req bit is set, select round-robin, searching from (last+1) mod N_REQ upward.
  - Latch grant_id and the payload into xfer_data, set xfer_req=1, clear the timeout counter, then go to REQ_HI.
  - If xfer_ack_sync==1 (stale ack), stay in IDLE and grant nothing.
- REQ_HI:
  - If xfer_ack_sync==1, set xfer_req=0 and go to ACK_LO.
  - Otherwise the counter increments each cycle. When it reaches TMO_CYC (TMO_CYC!=0), set xfer_req=0, set the internal err flag, and go to ACK_LO.
- ACK_LO: when xfer_ack_sync==0, go to DONE. There is no timeout in this state.
- DONE:
  - done[grant_id]=1 for exactly this cycle; err[grant_id]=err flag.
  - last<=grant_id, clear the err flag, go to IDLE.
  - No arbitration runs in this cycle.
- Requester contract: clear req[i] on the clock edge at which done[i] is sampled high. The block must then not re-grant the same request.
- Changes on req_data or req after the grant do not affect xfer_data or the transfer in flight.
- Dropping req[grant_id] mid-transfer does not abort the transfer; done is still pulsed.
- Reset values:
  - state IDLE
  - xfer_req=0, xfer_data=0, done=0, err=0, busy=0
  - grant_id=0, last=N_REQ-1, so requester 0 has top priority after reset
  - counter=0, err flag=0
- Reset mid-transfer: xfer_req drops asynchronously. The far-domain handshake side must be reset in the same reset event.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- req seen in IDLE at edge t gives xfer_req=1, busy=1, grant_id and xfer_data valid after edge t.
- xfer_ack_sync=1 sampled at edge k gives xfer_req=0 after edge k.
- xfer_ack_sync=0 sampled at edge m gives done high for the cycle after edge m, then IDLE.
- Minimum transfer is 4 cycles from grant to done, with ack responding immediately. Add the synchronizer latency in both directions.
- Back-to-back: the next grant happens at the earliest one cycle after done, in IDLE.
- Timeout: xfer_req falls after the edge at which the counter reaches TMO_CYC, i.e. TMO_CYC+1 cycles of xfer_req high with no ack.
- Simultaneous ack rise and timeout in the same cycle: the ack wins and err=0.

## Test plan
- Single request: req=4'b0100 with data 0xA5; ack loops back after 3 cycles each way. Required: grant_id=2, xfer_data=0xA5, xfer_req high until ack, done=4'b0100 one cycle, err=0.
- Round-robin: req=4'b1011 held, each requester clears its bit on done. Required grant order 0,1,3. Then re-raise req[0] and req[1] after the grant of 3: required order 0,1.
- Timeout: TMO_CYC=10, ack tied 0, req[1]=1. Required: xfer_req high for 11 cycles, then done[1]=err[1]=1 together, then IDLE.
- Stale ack: xfer_ack_sync=1 out of reset, req[0]=1. Required: no grant while ack=1; grant occurs the cycle after ack falls.
- Reset mid-transfer: assert a_rst_n in REQ_HI. Required: xfer_req=0, busy=0, done=0 immediately. After release with req[3]=1, requester 3 is granted.
- Payload isolation: change req_data slice 2 from 0x11 to 0xFF one cycle after grant. Required: xfer_data stays 0x11 until done.

Source files
------------

// File: rtl/cdc_hs_arbiter.sv
// cdc_hs_arbiter
//   Source-domain round-robin arbiter and four-phase handshake sequencer.
//   Several requesters share one 1-bit level-synchronized crossing channel.
//   The granted payload is latched and held on xfer_data while xfer_req is
//   raised. The block then waits for the synchronized acknowledge to rise
//   and fall, and pulses done (with err on a timeout) to the winner.
//
// Ports
//   a_clk          source-domain clock
//   a_rst_n        asynchronous reset, active-HIGH (despite the suffix)
//   req            per-requester request level, held until its done pulse
//   req_data       payload, slice i belongs to requester i
//   done           one-cycle completion pulse to the granted requester
//   err            one-cycle timeout flag, coincident with done
//   xfer_req       request level toward the bit synchronizer
//   xfer_data      latched payload, stable from xfer_req rise until done
//   xfer_ack_sync  acknowledge level, already synchronized into a_clk
//   busy           high whenever the sequencer is not idle
//   grant_id       current or last granted requester index
module cdc_hs_arbiter #(
   parameter int N_REQ   = 4,
   parameter int DATA_W  = 8,
   parameter int TMO_CYC = 255
) (
   input  logic                        a_clk,
   input  logic                        a_rst_n,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ*DATA_W-1:0]     req_data,
   output logic [N_REQ-1:0]            done,
   output logic [N_REQ-1:0]            err,
   output logic                        xfer_req,
   output logic [DATA_W-1:0]           xfer_data,
   input  logic                        xfer_ack_sync,
   output logic                        busy,
   output logic [$clog2(N_REQ)-1:0]    grant_id
);

   localparam int GID_W = $clog2(N_REQ);
   localparam int CNT_W = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
   localparam logic [CNT_W-1:0] TMO_V = CNT_W'(TMO_CYC);

   typedef enum logic [1:0] {IDLE, REQ_HI, ACK_LO, DONE} state_t;

   state_t            state, state_n;
   logic [GID_W-1:0]  last_id, last_n;
   logic [GID_W-1:0]  grant_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic              err_flag, err_flag_n;
   logic              xfer_req_n, busy_n;
   logic [DATA_W-1:0] xfer_data_n;
   logic [N_REQ-1:0]  done_n, err_n;

   logic              pick_vld;
   logic [GID_W-1:0]  pick_id;
   logic [DATA_W-1:0] pick_data;

   // Round-robin search starting just after the last served requester.
   always_comb begin
      pick_vld = 1'b0;
      pick_id  = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         logic [GID_W-1:0] idx;
         idx = GID_W'((int'(last_id) + k) % N_REQ);
         if (!pick_vld && req[idx]) begin
            pick_vld = 1'b1;
            pick_id  = idx;
         end
      end
   end

   // Payload mux for the winning requester.
   always_comb begin
      pick_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_id == GID_W'(i)) pick_data = req_data[i*DATA_W +: DATA_W];
      end
   end

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_n     = state;
      last_n      = last_id;
      grant_n     = grant_id;
      cnt_n       = cnt;
      err_flag_n  = err_flag;
      xfer_req_n  = xfer_req;
      xfer_data_n = xfer_data;
      done_n      = '0;
      err_n       = '0;
      case (state)
         IDLE: begin
            // A stale ack from a previous exchange blocks arbitration.
            if (!xfer_ack_sync && pick_vld) begin
               grant_n     = pick_id;
               xfer_data_n = pick_data;
               xfer_req_n  = 1'b1;
               cnt_n       = '0;
               state_n     = REQ_HI;
            end
         end
         REQ_HI: begin
            // The ack is tested first, so it wins over a coincident timeout.
            if (xfer_ack_sync) begin
               xfer_req_n = 1'b0;
               state_n    = ACK_LO;
            end else if (TMO_CYC != 0 && cnt == TMO_V) begin
               xfer_req_n = 1'b0;
               err_flag_n = 1'b1;
               state_n    = ACK_LO;
            end else if (TMO_CYC != 0) begin
               cnt_n = cnt + 1'b1;
            end
         end
         ACK_LO: begin
            if (!xfer_ack_sync) begin
               done_n[grant_id] = 1'b1;
               err_n[grant_id]  = err_flag;
               state_n          = DONE;
            end
         end
         DONE: begin
            // done is visible during this cycle; no arbitration here, so the
            // requester has one edge to drop its req.
            last_n     = grant_id;
            err_flag_n = 1'b0;
            state_n    = IDLE;
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge a_clk or posedge a_rst_n) begin
      if (a_rst_n) begin
         state     <= IDLE;
         last_id   <= GID_W'(N_REQ - 1);
         grant_id  <= '0;
         cnt       <= '0;
         err_flag  <= 1'b0;
         xfer_req  <= 1'b0;
         xfer_data <= '0;
         done      <= '0;
         err       <= '0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         last_id   <= last_n;
         grant_id  <= grant_n;
         cnt       <= cnt_n;
         err_flag  <= err_flag_n;
         xfer_req  <= xfer_req_n;
         xfer_data <= xfer_data_n;
         done      <= done_n;
         err       <= err_n;
         busy      <= busy_n;
      end
   end

endmodule

// File: tb/tb_cdc_hs_arbiter.sv
// Testbench for cdc_hs_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level round-robin model.
module tb_cdc_hs_arbiter;

   localparam int NR  = 4;
   localparam int DW  = 8;
   localparam int TMO = 10;

   logic          a_clk = 1'b0;
   logic          rst;
   logic [NR-1:0] req;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0] done, err;
   logic          xfer_req;
   logic [DW-1:0] xfer_data;
   logic          ack_sync;
   logic          busy;
   logic [1:0]    grant_id;

   // Far side: request loops back as ack after 3 + 3 synchronizer cycles.
   logic [5:0]    pipe;
   logic          force_en, force_val;
   logic          auto_clr;
   int            nvec, nerr, model_last;

   always #5 a_clk = ~a_clk;

   always @(posedge a_clk or posedge rst) begin
      if (rst) pipe <= '0;
      else     pipe <= {pipe[4:0], xfer_req};
   end
   assign ack_sync = force_en ? force_val : pipe[5];

   cdc_hs_arbiter #(.N_REQ(NR), .DATA_W(DW), .TMO_CYC(TMO)) dut (
      .a_clk(a_clk), .a_rst_n(rst), .req(req), .req_data(req_data),
      .done(done), .err(err), .xfer_req(xfer_req), .xfer_data(xfer_data),
      .xfer_ack_sync(ack_sync), .busy(busy), .grant_id(grant_id)
   );

   // Round-robin reference: first set bit searching upward from last+1.
   function automatic int rr_pick(int last, logic [NR-1:0] r);
      for (int k = 1; k <= NR; k++) begin
         int i;
         i = (last + k) % NR;
         if (r[i]) return i;
      end
      return -1;
   endfunction

   task automatic tick();
      @(negedge a_clk);
      if (auto_clr) req = req & ~done;
   endtask

   task automatic wait_grant(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (busy) begin ok = 1'b1; return; end
         tick();
      end
   endtask

   task automatic wait_done(output bit ok, output int hi, output int nt, output bit stable);
      logic [DW-1:0] d0;
      ok = 1'b0; hi = 0; nt = 0; stable = 1'b1; d0 = xfer_data;
      for (int i = 0; i < 60; i++) begin
         if (xfer_req) hi++;
         if (xfer_data !== d0) stable = 1'b0;
         if (done !== '0) begin ok = 1'b1; return; end
         tick();
         nt++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge a_clk);
      nvec++; if (xfer_req !== 1'b0) begin nerr++; $display("FAIL rst_xfer_req: got %b want 0", xfer_req); end
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy: got %b want 0", busy); end
      nvec++; if (done !== 4'b0) begin nerr++; $display("FAIL rst_done: got %b want 0000", done); end
      nvec++; if (err !== 4'b0) begin nerr++; $display("FAIL rst_err: got %b want 0000", err); end
      nvec++; if (grant_id !== 2'd0) begin nerr++; $display("FAIL rst_gid: got %0d want 0", grant_id); end
      nvec++; if (xfer_data !== 8'h00) begin nerr++; $display("FAIL rst_data: got %h want 00", xfer_data); end
      rst = 1'b0;
      model_last = NR - 1;
      tick();
   endtask

   task automatic test_single();
      bit ok, st; int hi, nt;
      req_data[2*DW +: DW] = 8'hA5;
      req = 4'b0100;
      wait_grant(ok);
      nvec++; if (!ok) begin nerr++; $display("FAIL single_grant: got none want grant"); end
      nvec++; if (grant_id !== 2'd2) begin nerr++; $display("FAIL single_gid: got %0d want 2", grant_id); end
      nvec++; if (xfer_data !== 8'hA5) begin nerr++; $display("FAIL single_data: got %h want a5", xfer_data); end
      wait_done(ok, hi, nt, st);
      nvec++; if (!ok) begin nerr++; $display("FAIL single_done_wait: got none want done"); end
      nvec++; if (done !== 4'b0100) begin nerr++; $display("FAIL single_done: got %b want 0100", done); end
      nvec++; if (err !== 4'b0000) begin nerr++; $display("FAIL single_err: got %b want 0000", err); end
      nvec++; if (hi !== 7) begin nerr++; $display("FAIL single_req_hi: got %0d want 7", hi); end
      nvec++; if (nt !== 14) begin nerr++; $display("FAIL single_latency: got %0d want 14", nt); end
      nvec++; if (!st) begin nerr++; $display("FAIL single_stable: got unstable want stable"); end
      model_last = 2;
      tick();
      nvec++; if (done !== 4'b0 || busy !== 1'b0) begin nerr++; $display("FAIL single_after: got done=%b busy=%b want 0000/0", done, busy); end
   endtask

   task automatic test_round_robin();
      int exp_ord [5] = '{0, 1, 3, 0, 1};
      bit ok, st; int hi, nt;
      rst = 1'b1; tick(); rst = 1'b0; model_last = NR - 1;
      req = 4'b1011;
      for (int j = 0; j < 5; j++) begin
         wait_grant(ok);
         nvec++; if (!ok || int'(grant_id) !== exp_ord[j]) begin nerr++; $display("FAIL rr_order%0d: got %0d want %0d", j, grant_id, exp_ord[j]); end
         if (j == 2) req = req | 4'b0011;
         wait_done(ok, hi, nt, st);
         nvec++; if (done !== 4'(1 << exp_ord[j])) begin nerr++; $display("FAIL rr_done%0d: got %b want %b", j, done, 4'(1 << exp_ord[j])); end
         model_last = exp_ord[j];
         tick();
      end
   endtask

   task automatic test_timeout();
      bit ok, st; int hi, nt;
      force_en = 1'b1; force_val = 1'b0;
      req = 4'b0010;
      wait_grant(ok);
      nvec++; if (!ok || grant_id !== 2'd1) begin nerr++; $display("FAIL tmo_gid: got %0d want 1", grant_id); end
      wait_done(ok, hi, nt, st);
      nvec++; if (hi !== TMO + 1) begin nerr++; $display("FAIL tmo_req_hi: got %0d want %0d", hi, TMO + 1); end
      nvec++; if (done !== 4'b0010 || err !== 4'b0010) begin nerr++; $display("FAIL tmo_done_err: got %b/%b want 0010/0010", done, err); end
      model_last = 1;
      tick();
      nvec++; if (done !== 4'b0 || err !== 4'b0 || busy !== 1'b0) begin nerr++; $display("FAIL tmo_after: got %b/%b/%b want 0000/0000/0", done, err, busy); end
      repeat (8) tick();
      force_en = 1'b0;
   endtask

   task automatic test_ack_tmo_tie();
      bit ok, st; int hi, nt;
      force_en = 1'b1; force_val = 1'b0;
      req = 4'b0001;
      wait_grant(ok);
      repeat (TMO) tick();
      force_val = 1'b1;   // sampled on the same edge the counter expires
      tick();
      nvec++; if (xfer_req !== 1'b0 || busy !== 1'b1) begin nerr++; $display("FAIL tie_req: got %b/%b want 0/1", xfer_req, busy); end
      force_val = 1'b0;
      wait_done(ok, hi, nt, st);
      nvec++; if (done !== 4'b0001 || err !== 4'b0000) begin nerr++; $display("FAIL tie_err: got %b/%b want 0001/0000", done, err); end
      model_last = 0;
      repeat (8) tick();
      force_en = 1'b0;
   endtask

   task automatic test_stale_ack();
      bit ok, st, early; int hi, nt;
      rst = 1'b1; force_en = 1'b1; force_val = 1'b1; req = 4'b0001;
      tick(); rst = 1'b0; model_last = NR - 1;
      early = 1'b0;
      repeat (5) begin tick(); if (busy || xfer_req) early = 1'b1; end
      nvec++; if (early) begin nerr++; $display("FAIL stale_nogrant: got grant want none"); end
      force_val = 1'b0;
      tick();
      nvec++; if (busy !== 1'b1 || grant_id !== 2'd0) begin nerr++; $display("FAIL stale_grant: got %b/%0d want 1/0", busy, grant_id); end
      force_en = 1'b0;
      wait_done(ok, hi, nt, st);
      nvec++; if (done !== 4'b0001) begin nerr++; $display("FAIL stale_done: got %b want 0001", done); end
      model_last = 0;
      tick();
   endtask

   task automatic test_reset_mid();
      bit ok, st; int hi, nt;
      req = 4'b0100;
      req_data[3*DW +: DW] = 8'h3C;
      wait_grant(ok);
      tick(); tick();
      #2 rst = 1'b1;
      #1;
      nvec++; if (xfer_req !== 1'b0 || busy !== 1'b0 || done !== 4'b0) begin nerr++; $display("FAIL rstmid_async: got %b/%b/%b want 0/0/0000", xfer_req, busy, done); end
      req = 4'b1000;
      tick(); rst = 1'b0; model_last = NR - 1;
      wait_grant(ok);
      nvec++; if (!ok || grant_id !== 2'd3 || xfer_data !== 8'h3C) begin nerr++; $display("FAIL rstmid_grant: got %0d/%h want 3/3c", grant_id, xfer_data); end
      wait_done(ok, hi, nt, st);
      nvec++; if (done !== 4'b1000) begin nerr++; $display("FAIL rstmid_done: got %b want 1000", done); end
      model_last = 3;
      tick();
   endtask

   task automatic test_payload_iso();
      bit ok, st; int hi, nt;
      req_data[2*DW +: DW] = 8'h11;
      req = 4'b0100;
      wait_grant(ok);
      nvec++; if (xfer_data !== 8'h11) begin nerr++; $display("FAIL iso_grant_data: got %h want 11", xfer_data); end
      tick();
      req_data[2*DW +: DW] = 8'hFF;
      req[2] = 1'b0;      // dropping req mid-transfer must not abort it
      wait_done(ok, hi, nt, st);
      nvec++; if (!ok || !st || xfer_data !== 8'h11) begin nerr++; $display("FAIL iso_stable: got %h stable=%b want 11/1", xfer_data, st); end
      nvec++; if (done !== 4'b0100) begin nerr++; $display("FAIL iso_done: got %b want 0100", done); end
      model_last = 2;
      repeat (3) tick();
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL iso_regrant: got busy=%b want 0", busy); end
   endtask

   task automatic test_random();
      logic [NR-1:0]    pre_req;
      logic [NR*DW-1:0] pre_data;
      logic [DW-1:0]    exp_d;
      int cur, ngrant, ndone;
      bit busy_q;
      auto_clr = 1'b0; busy_q = busy; cur = 0; ngrant = 0; ndone = 0;
      for (int cyc = 0; cyc < 3000 && ndone < 60; cyc++) begin
         pre_req = req; pre_data = req_data;
         @(negedge a_clk);
         if (busy && !busy_q) begin
            cur = rr_pick(model_last, pre_req);
            exp_d = pre_data[(cur & 3)*DW +: DW];
            nvec++; if (int'(grant_id) !== cur) begin nerr++; $display("FAIL rnd_gid: got %0d want %0d", grant_id, cur); end
            nvec++; if (xfer_data !== exp_d) begin nerr++; $display("FAIL rnd_data: got %h want %h", xfer_data, exp_d); end
            ngrant++;
         end
         if (done !== '0) begin
            nvec++; if (done !== 4'(1 << (cur & 3)) || err !== 4'b0) begin nerr++; $display("FAIL rnd_done: got %b/%b want %b/0000", done, err, 4'(1 << (cur & 3))); end
            model_last = cur;
            ndone++;
            req = req & ~done;
         end
         busy_q = busy;
         for (int i = 0; i < NR; i++) begin
            if (!req[i] && !done[i] && $urandom_range(0, 7) == 0) begin
               req_data[i*DW +: DW] = 8'($urandom);
               req[i] = 1'b1;
            end
         end
      end
      nvec++; if (ndone < 20) begin nerr++; $display("FAIL rnd_progress: got %0d transfers want >=20", ndone); end
      auto_clr = 1'b1;
   endtask

   initial begin
      rst = 1'b1; req = '0; req_data = '0;
      force_en = 1'b0; force_val = 1'b0; auto_clr = 1'b1;
      nvec = 0; nerr = 0; model_last = NR - 1;
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_ack_tmo_tie();
      test_stale_ack();
      test_reset_mid();
      test_payload_iso();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
